// File: rtl/miriscv_mul_radix.sv
// Iterative radix-2^BITS_PER_CYCLE shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional product cache for back-to-back fused ops: define MIRISCV_MUL_FUSE_EN.
`timescale 1ns/1ps

package miriscv_mdu_pkg;
  localparam int MDU_OP_W = 3;
  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
endpackage

module miriscv_mul_radix
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mul_start_i,
  input  logic [XLEN-1:0]     port_a_i,
  input  logic [XLEN-1:0]     port_b_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic                kill_i,
  input  logic                keep_i,
  output logic [XLEN-1:0]     mul_result_o,
  output logic                mul_stall_req_o
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = XLEN / BPC;
  localparam int CNT_W = $clog2(N + 1);

  if (!((BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) && (XLEN % BPC == 0))) begin : g_param_err
    $error("miriscv_mul_radix: illegal BITS_PER_CYCLE %0d for XLEN %0d", BITS_PER_CYCLE, XLEN);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMP   = 2'd1,
    SIGN   = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_inv_q, sign_inv_d;
  logic                is_mul_q, is_mul_d;

  logic                a_signed, b_signed, sign_a, sign_b;
  logic [XLEN+BPC-1:0] part;
  logic [2*XLEN+BPC-1:0] sum;

  assign a_signed = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU);
  assign b_signed = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH);
  assign sign_a   = a_signed & port_a_i[XLEN-1];
  assign sign_b   = b_signed & port_b_i[XLEN-1];

  // Accumulator holds the partial product pre-shifted so the full product lands in place after N steps.
  assign part = {{BPC{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[BPC-1:0]};
  assign sum  = {{BPC{1'b0}}, acc_q} + {part, {XLEN{1'b0}}};

`ifdef MIRISCV_MUL_FUSE_EN
  logic [XLEN-1:0] ca_q, ca_d;
  logic [XLEN-1:0] cb_q, cb_d;
  logic [1:0]      cls_q, cls_d;
  logic            cvld_q, cvld_d;
  logic [1:0]      op_cls;
  logic            hit;

  // Signedness class: 0 = SS, 1 = SU, 2 = UU.
  assign op_cls = (mdu_op_i == MDU_MULHSU) ? 2'd1 :
                  (mdu_op_i == MDU_MULHU)  ? 2'd2 : 2'd0;
  assign hit    = cvld_q && (port_a_i == ca_q) && (port_b_i == cb_q) &&
                  ((mdu_op_i == MDU_MUL) || (op_cls == cls_q));
`else
  logic hit;
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    sign_inv_d = sign_inv_q;
    is_mul_d   = is_mul_q;
`ifdef MIRISCV_MUL_FUSE_EN
    ca_d   = ca_q;
    cb_d   = cb_q;
    cls_d  = cls_q;
    cvld_d = cvld_q;
`endif
    case (state_q)
      IDLE: begin
        if (mul_start_i) begin
          is_mul_d = (mdu_op_i == MDU_MUL);
          if (hit) begin
            state_d = FINISH;
          end else begin
            a_d   = sign_a ? (~port_a_i + 1'b1) : port_a_i;
            b_d   = sign_b ? (~port_b_i + 1'b1) : port_b_i;
            acc_d = '0;
            cnt_d = CNT_W'(N);
            case (mdu_op_i)
              MDU_MUL, MDU_MULH: sign_inv_d = sign_a ^ sign_b;
              MDU_MULHSU:        sign_inv_d = sign_a & (|port_b_i);
              default:           sign_inv_d = 1'b0;
            endcase
            state_d = COMP;
`ifdef MIRISCV_MUL_FUSE_EN
            ca_d   = port_a_i;
            cb_d   = port_b_i;
            cls_d  = op_cls;
            cvld_d = 1'b0;
`endif
          end
        end
      end
      COMP: begin
        acc_d = sum[2*XLEN+BPC-1:BPC];
        b_d   = b_q >> BPC;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = sign_inv_q ? SIGN : FINISH;
      end
      SIGN: begin
        acc_d   = '0 - acc_q;
        state_d = FINISH;
      end
      FINISH: begin
        if (!keep_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef MIRISCV_MUL_FUSE_EN
    if (state_d == FINISH && state_q != FINISH) cvld_d = 1'b1;
    if (kill_i) cvld_d = 1'b0;
`endif
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      sign_inv_q <= 1'b0;
      is_mul_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      sign_inv_q <= sign_inv_d;
      is_mul_q   <= is_mul_d;
    end
  end

`ifdef MIRISCV_MUL_FUSE_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ca_q   <= '0;
      cb_q   <= '0;
      cls_q  <= '0;
      cvld_q <= 1'b0;
    end else begin
      ca_q   <= ca_d;
      cb_q   <= cb_d;
      cls_q  <= cls_d;
      cvld_q <= cvld_d;
    end
  end
`endif

  assign mul_result_o    = (state_q != FINISH) ? '0 :
                           is_mul_q ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
  assign mul_stall_req_o = mul_start_i && (state_q != FINISH);

endmodule

// File: tb/tb_miriscv_mul_radix.sv
// Directed bench for miriscv_mul_radix (XLEN=32, BITS_PER_CYCLE=4).
`timescale 1ns/1ps

module tb_miriscv_mul_radix;
  import miriscv_mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        mul_start_i;
  logic [31:0] port_a_i, port_b_i;
  logic [MDU_OP_W-1:0] mdu_op_i;
  logic        kill_i, keep_i;
  logic [31:0] mul_result_o;
  logic        mul_stall_req_o;

  int total = 0;
  int bad   = 0;

  miriscv_mul_radix #(.XLEN(32), .BITS_PER_CYCLE(4)) dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .mul_start_i     (mul_start_i),
    .port_a_i        (port_a_i),
    .port_b_i        (port_b_i),
    .mdu_op_i        (mdu_op_i),
    .kill_i          (kill_i),
    .keep_i          (keep_i),
    .mul_result_o    (mul_result_o),
    .mul_stall_req_o (mul_stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      MDU_MUL, MDU_MULH: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MDU_MULHSU:        p = {{32{a[31]}}, a} * {32'd0, b};
      default:           p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == MDU_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Runs one operation; operands are scrambled after capture to show they are ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_stall, input int keep_n,
                        input string tag);
    int n;
    @(negedge clk_i);
    mdu_op_i = op; port_a_i = a; port_b_i = b; mul_start_i = 1'b1;
    #1;
    n = 0;
    while (mul_stall_req_o && n < 50) begin
      n++;
      @(negedge clk_i);
      if (n == 1) begin
        port_a_i = ~a; port_b_i = b ^ 32'h5a5a_1234; mdu_op_i = op ^ 3'd1;
      end
    end
    chk({tag, "_stall"}, n, exp_stall);
    chk({tag, "_res"}, mul_result_o, exp_res);
    if (keep_n > 0) begin
      keep_i = 1'b1; mul_start_i = 1'b0;
      for (int k = 0; k < keep_n; k++) begin
        @(negedge clk_i);
        chk({tag, "_keep"}, mul_result_o, exp_res);
      end
      keep_i = 1'b0;
    end
    mul_start_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_idle"}, mul_result_o, 32'd0);
  endtask

  initial begin
    int fuse_stall;
    arst_i = 1'b1; mul_start_i = 1'b0; port_a_i = '0; port_b_i = '0;
    mdu_op_i = MDU_MUL; kill_i = 1'b0; keep_i = 1'b0;
    #12;
    chk("rst_res", mul_result_o, 32'd0);
    chk("rst_stall0", {31'd0, mul_stall_req_o}, 32'd0);
    mul_start_i = 1'b1; #1;
    chk("rst_stall1", {31'd0, mul_stall_req_o}, 32'd1);
    mul_start_i = 1'b0;
    @(negedge clk_i); arst_i = 1'b0;

    run_op(MDU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, 0, "mul_7_m3");
    run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 0, "mulhu_max");
    run_op(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, 0, "mulh_min");
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0, "mulhsu_m1");
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'd0,         32'd0,         9, 0, "mulhsu_zero");

    // Kill on the fourth COMP cycle.
    @(negedge clk_i);
    mdu_op_i = MDU_MULH; port_a_i = 32'h1234_5678; port_b_i = 32'hFFFF_FFFE; mul_start_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("kill_busy", {31'd0, mul_stall_req_o}, 32'd1);
    kill_i = 1'b1; mul_start_i = 1'b0;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill_res", mul_result_o, 32'd0);
    run_op(MDU_MUL, 32'd3, 32'd5, 32'd15, 9, 5, "mul_3x5_keep");

    run_op(MDU_MUL,  32'd0,        32'h0000_1234, 32'd0,         9, 0, "mul_zero");
    run_op(MDU_MULH, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 10, 0, "mulh_m1x1");

    // Asynchronous reset in the middle of COMP.
    @(negedge clk_i);
    mdu_op_i = MDU_MULHU; port_a_i = 32'hFFFF_FFFF; port_b_i = 32'd2; mul_start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2 arst_i = 1'b1;
    #1;
    chk("arst_res", mul_result_o, 32'd0);
    chk("arst_stall1", {31'd0, mul_stall_req_o}, 32'd1);
    mul_start_i = 1'b0; #1;
    chk("arst_stall0", {31'd0, mul_stall_req_o}, 32'd0);
    @(negedge clk_i); arst_i = 1'b0;
    run_op(MDU_MUL, 32'd6, 32'd7, 32'd42, 9, 0, "mul_after_rst");

`ifdef MIRISCV_MUL_FUSE_EN
    fuse_stall = 1;
`else
    fuse_stall = 10;
`endif
    run_op(MDU_MULH,  32'h1234_5678, 32'h9ABC_DEF0,
           ref_mul(MDU_MULH, 32'h1234_5678, 32'h9ABC_DEF0), 10, 0, "fuse_mulh");
    run_op(MDU_MUL,   32'h1234_5678, 32'h9ABC_DEF0,
           ref_mul(MDU_MUL, 32'h1234_5678, 32'h9ABC_DEF0), fuse_stall, 0, "fuse_mul");
    run_op(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
           ref_mul(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 9, 0, "fuse_mulhu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
